// File: rtl/mem_ir_stage_pkg.sv
// Purpose: definitions shared by the multicycle MIPS core. This file holds
//          opcode/funct constants, the instruction field bit positions, the
//          FSM state encodings and the default bus timeout.
// Ports:   none (package).
package mips_mc_pkg;

    // Default bus timeout and the timer width that can hold it (1..255)
    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned TIMER_W         = 8;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // Instruction field bit positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned FN_LSB  = 0;

    // Memory stage FSM encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_DONE = ST_DONE_ENC
    } mem_state_t;

    // Kind of access latched when a bus cycle is issued
    typedef enum logic [1:0] {
        K_FETCH = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } access_kind_t;

endpackage

// File: rtl/mem_ir_stage_if.sv
// Purpose: req/ack bus for the shared instruction/data memory.
// Ports:   master = memory stage (drives req/we/addr/wdata, receives rdata/ack)
//          slave  = memory model (the reverse).
interface mem_ir_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_ir_stage_timer.sv
// Purpose: bus_timeout_timer is a saturating cycle counter with a terminal-count
//          flag. It is used to bound how long a requester waits for an ack.
// Ports:   clk, rst   clock, synchronous active-high reset
//          i_clr      restart the count at zero
//          i_en       count one cycle
//          o_tc_c     count == TERM-1 (combinational)
module bus_timeout_timer #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TERM  = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TERM - 1);
    localparam logic [CNT_W-1:0] SAT_VAL = '1;

    logic [CNT_W-1:0] r_count;

    // Counter holds at all-ones so it can never wrap back below the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != SAT_VAL)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == TC_VAL);
endmodule

// File: rtl/mem_ir_stage.sv
// Purpose: memory-access / instruction-register stage of the multicycle MIPS
//          core. It turns IR_Write / Mem_Write / IorD strobes into one req/ack bus
//          transfer and holds the IR and the MDR.
// Ports:   clk, rst                   clock, synchronous active-high reset
//          pc, alu_out, wd            fetch address, data address, store data
//          IorD, Mem_Write, IR_Write  control strobes
//          bus                        memory bus (master side)
//          instr, Op, Funct, rs, rt, rd, imm   IR and its decoded fields
//          mdr                        memory data register
//          busy                       stall request (combinational)
//          align_err, bus_err         one-cycle error pulses
module mem_ir_stage
    import mips_mc_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] wd,
    input  logic             IorD,
    input  logic             Mem_Write,
    input  logic             IR_Write,
    mem_ir_stage_if.master   bus,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic [WIDTH-1:0] mdr,
    output logic             busy,
    output logic             align_err,
    output logic             bus_err
);
    mem_state_t       r_state,     w_state_nxt;
    access_kind_t     r_kind,      w_kind_nxt;
    logic             r_mem_req,   w_mem_req_nxt;
    logic             r_mem_we,    w_mem_we_nxt;
    logic [WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [WIDTH-1:0] r_instr,     w_instr_nxt;
    logic [WIDTH-1:0] r_mdr,       w_mdr_nxt;
    logic             r_align_err, w_align_err_nxt;
    logic             r_bus_err,   w_bus_err_nxt;

    logic             w_fetch, w_store, w_load, w_cmd, w_aligned;
    logic [WIDTH-1:0] w_addr;
    logic             w_tmr_clr, w_tmr_en, w_tmr_tc;

    // Command decode with priority FETCH > STORE > LOAD
    assign w_fetch   = IR_Write;
    assign w_store   = Mem_Write & ~IR_Write;
    assign w_load    = IorD & ~Mem_Write & ~IR_Write;
    assign w_cmd     = w_fetch | w_store | w_load;
    // A fetch always uses pc, even when IorD is also high
    assign w_addr    = (IorD && !w_fetch) ? alu_out : pc;
    assign w_aligned = (w_addr[1:0] == 2'b00);

    bus_timeout_timer #(
        .CNT_W (TIMER_W),
        .TERM  (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_tc_c (w_tmr_tc)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_kind      <= K_FETCH;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_instr     <= '0;
            r_mdr       <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_kind      <= w_kind_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_instr     <= w_instr_nxt;
            r_mdr       <= w_mdr_nxt;
            r_align_err <= w_align_err_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt     = r_state;
        w_kind_nxt      = r_kind;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_instr_nxt     = r_instr;
        w_mdr_nxt       = r_mdr;
        w_align_err_nxt = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    if (w_aligned) begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = w_store;
                        w_mem_addr_nxt  = w_addr;
                        w_mem_wdata_nxt = w_store ? wd : '0;
                        w_kind_nxt      = w_fetch ? K_FETCH : (w_store ? K_STORE : K_LOAD);
                        w_tmr_clr       = 1'b1;
                        w_state_nxt     = ST_REQ;
                    end else begin
                        w_align_err_nxt = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                // An ack takes priority over a timeout that falls in the same cycle
                if (bus.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    case (r_kind)
                        K_FETCH: w_instr_nxt = bus.mem_rdata;
                        K_LOAD:  w_mdr_nxt   = bus.mem_rdata;
                        default: ;
                    endcase
                    w_state_nxt = ST_DONE;
                end else if (w_tmr_tc) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            // One-cycle guard so a strobe that is still held does not re-issue
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_REQ) | ((r_state == ST_IDLE) & w_cmd & w_aligned);

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign instr     = r_instr;
    assign mdr       = r_mdr;
    assign align_err = r_align_err;
    assign bus_err   = r_bus_err;

    assign Op    = r_instr[OP_MSB:OP_LSB];
    assign Funct = r_instr[FN_MSB:FN_LSB];
    assign rs    = r_instr[RS_MSB:RS_LSB];
    assign rt    = r_instr[RT_MSB:RT_LSB];
    assign rd    = r_instr[RD_MSB:RD_LSB];
    assign imm   = r_instr[IMM_MSB:IMM_LSB];
endmodule

// File: tb/tb_mem_ir_stage.sv
// Purpose: self-checking bench for mem_ir_stage. It runs directed test-plan
//          cases and then randomized accesses. The expected values come from a
//          transaction-level model of the IR and the MDR.
module tb_mem_ir_stage;
    import mips_mc_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc, alu_out, wd;
    logic         IorD, Mem_Write, IR_Write;
    logic [W-1:0] instr, mdr;
    logic [5:0]   Op, Funct;
    logic [4:0]   rs, rt, rd;
    logic [15:0]  imm;
    logic         busy, align_err, bus_err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the architectural registers
    logic [W-1:0] m_instr = '0;
    logic [W-1:0] m_mdr   = '0;

    always #5 clk = ~clk;

    mem_ir_stage_if #(.WIDTH(W)) bus ();

    mem_ir_stage #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .alu_out(alu_out), .wd(wd),
        .IorD(IorD), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .bus(bus), .instr(instr), .Op(Op), .Funct(Funct),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .mdr(mdr),
        .busy(busy), .align_err(align_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_mdr"},   mdr,   m_mdr);
        chk({tag, "_op"},    W'(Op),    W'(m_instr[31:26]));
        chk({tag, "_funct"}, W'(Funct), W'(m_instr[5:0]));
        chk({tag, "_rs"},    W'(rs),    W'(m_instr[25:21]));
        chk({tag, "_rt"},    W'(rt),    W'(m_instr[20:16]));
        chk({tag, "_rd"},    W'(rd),    W'(m_instr[15:11]));
        chk({tag, "_imm"},   W'(imm),   W'(m_instr[15:0]));
    endtask

    // One complete access: an IDLE cycle, then the REQ cycles, then DONE and one
    // IDLE cycle. dly is the REQ-cycle index of the ack; dly >= TO means no ack.
    task automatic txn(input logic iw, input logic mw, input logic iord,
                       input logic [W-1:0] p, input logic [W-1:0] a, input logic [W-1:0] w,
                       input int dly, input logic [W-1:0] rdat, input bit hold);
        bit f, s, l, cmd, al, acked;
        logic [W-1:0] ad;
        int nreq, busy_n, req_n;
        f     = iw;
        s     = mw && !iw;
        l     = iord && !mw && !iw;
        cmd   = f || s || l;
        ad    = (iord && !f) ? a : p;
        al    = (ad[1:0] == 2'b00);
        acked = (dly < int'(TO));
        nreq  = acked ? dly + 1 : int'(TO);
        busy_n = 0;
        req_n  = 0;

        @(negedge clk);
        IR_Write = iw; Mem_Write = mw; IorD = iord;
        pc = p; alu_out = a; wd = w;
        // A stray ack while idle must be ignored
        bus.mem_ack   = !cmd;
        bus.mem_rdata = $urandom;
        #1;
        chk("idle_req", W'(bus.mem_req), '0);
        chk("idle_busy", W'(busy), W'(cmd && al));
        busy_n += int'(busy);
        if (!cmd) return;

        if (al) begin
            for (int i = 0; i < nreq; i++) begin
                @(negedge clk);
                if (!hold) begin IR_Write = 1'b0; Mem_Write = 1'b0; IorD = 1'b0; end
                bus.mem_ack   = (i == dly);
                bus.mem_rdata = (i == dly) ? rdat : W'($urandom);
                #1;
                chk("req_req",  W'(bus.mem_req), W'(1));
                chk("req_we",   W'(bus.mem_we),  W'(s));
                chk("req_addr", bus.mem_addr,    ad);
                if (s) chk("req_wdata", bus.mem_wdata, w);
                chk("req_busy", W'(busy), W'(1));
                busy_n += int'(busy);
                req_n  += int'(bus.mem_req);
            end
            if (acked && f) m_instr = rdat;
            if (acked && l) m_mdr   = rdat;
        end

        // DONE cycle; strobes may still be held and a stray ack must be ignored
        @(negedge clk);
        if (!hold) begin IR_Write = 1'b0; Mem_Write = 1'b0; IorD = 1'b0; end
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        chk("done_req",   W'(bus.mem_req), '0);
        chk("done_we",    W'(bus.mem_we),  '0);
        chk("done_busy",  W'(busy), '0);
        chk("align_err",  W'(align_err), W'(!al));
        chk("bus_err",    W'(bus_err),   W'(al && !acked));
        chk_regs("done");
        busy_n += int'(busy);
        req_n  += int'(bus.mem_req);

        @(negedge clk);
        IR_Write = 1'b0; Mem_Write = 1'b0; IorD = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        chk("after_req",  W'(bus.mem_req), '0);
        chk("after_aerr", W'(align_err), '0);
        chk("after_berr", W'(bus_err),   '0);
        chk_regs("after");

        chk("busy_cycles", W'(busy_n), (cmd && al) ? W'(nreq + 1) : '0);
        chk("req_cycles",  W'(req_n),  (cmd && al) ? W'(nreq) : '0);
    endtask

    initial begin
        rst = 1'b1;
        pc = '0; alu_out = '0; wd = '0;
        IorD = 1'b0; Mem_Write = 1'b0; IR_Write = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   W'(bus.mem_req), '0);
        chk("rst_we",    W'(bus.mem_we),  '0);
        chk("rst_addr",  bus.mem_addr,  '0);
        chk("rst_wdata", bus.mem_wdata, '0);
        chk("rst_aerr",  W'(align_err), '0);
        chk("rst_berr",  W'(bus_err),   '0);
        chk("rst_busy",  W'(busy), '0);
        chk_regs("rst");
        rst = 1'b0;

        // Zero-wait fetch of addi $t0,$zero,5
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 32'h2008_0005, 1'b0);
        chk("tp_fetch_op",  W'(Op),  W'(OP_ADDI));
        chk("tp_fetch_rt",  W'(rt),  W'(8));
        chk("tp_fetch_imm", W'(imm), W'(5));
        // Load with wait states: ack in the third REQ cycle
        txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        chk("tp_load_mdr",   mdr,   32'hDEAD_BEEF);
        chk("tp_load_instr", instr, 32'h2008_0005);
        // Store, strobe held through DONE
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0104, 32'h1234_5678, 1, 32'hFFFF_0000, 1'b1);
        // Misaligned store
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0102, 32'hAAAA_5555, 0, 32'h0, 1'b0);
        // Fetch wins over a simultaneous store
        txn(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0108, 32'h7777_7777, 0, 32'h8C09_0004, 1'b0);
        // Load timeout
        txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h0, 99, 32'h0, 1'b0);

        // Reset during REQ, then a late ack
        @(negedge clk);
        IR_Write = 1'b1; pc = 32'h0000_0080; #1;
        chk("rmid_busy", W'(busy), W'(1));
        @(negedge clk);
        IR_Write = 1'b0; rst = 1'b1; #1;
        chk("rmid_inreq", W'(bus.mem_req), W'(1));
        @(negedge clk);
        rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF; #1;
        m_instr = '0; m_mdr = '0;
        chk("rmid_req",  W'(bus.mem_req), '0);
        chk("rmid_addr", bus.mem_addr, '0);
        chk("rmid_busy0", W'(busy), '0);
        chk_regs("rmid");
        @(negedge clk);
        bus.mem_ack = 1'b0; #1;
        chk("rmid_late_req", W'(bus.mem_req), '0);
        chk_regs("rmid_late");

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            logic iw, mw, io;
            logic [W-1:0] p, a;
            iw = ($urandom_range(0, 2) == 0);
            mw = 1'($urandom_range(0, 1));
            io = 1'($urandom_range(0, 1));
            p  = $urandom & ~W'(3);
            a  = $urandom & ~W'(3);
            if ($urandom_range(0, 4) == 0) p[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            txn(iw, mw, io, p, a, $urandom, int'($urandom_range(0, 5)), $urandom,
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_ir_stage.md
Name: mem_ir_stage

Overview:
- Memory-access and instruction-register stage of the multicycle MIPS core, sitting directly upstream of the control FSM.
- Consumes the control strobes IorD, Mem_Write and IR_Write, and drives one shared instruction/data memory through a req/ack bus.
- Holds the Instruction Register and the Memory Data Register.
- Feeds Op/Funct and the instruction fields back to the control unit and datapath; raises busy while a bus transfer is outstanding.

Parameters:
- WIDTH, 32, data and address width in bits.
- TIMEOUT_CYC, 255, maximum cycles to wait for mem_ack before aborting; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  WIDTH  byte address used for fetches (IorD=0).
- alu_out  in  WIDTH  byte address used for loads and stores (IorD=1).
- wd  in  WIDTH  store data (register B).
- IorD  in  1  address select; data access when 1.
- Mem_Write  in  1  store command.
- IR_Write  in  1  fetch command.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  WIDTH  bus byte address.
- mem_wdata  out  WIDTH  bus write data.
- mem_rdata  in  WIDTH  bus read data; valid while mem_ack=1.
- mem_ack  in  1  bus completion, one-cycle pulse.
- instr  out  WIDTH  Instruction Register.
- Op  out  6  instr[31:26].
- Funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- imm  out  16  instr[15:0].
- mdr  out  WIDTH  Memory Data Register.
- busy  out  1  stall request to the control unit.
- align_err  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: transfer timed out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, instr, mdr, align_err, bus_err, timer all cleared to 0.
  - Op, Funct and the field outputs are therefore 0.
- Command decode, sampled only in IDLE:
  - FETCH = IR_Write.
  - STORE = Mem_Write & ~IR_Write.
  - LOAD = IorD & ~Mem_Write & ~IR_Write.
  - Priority is FETCH > STORE > LOAD; a lower command asserted alongside FETCH is dropped.
- Address: addr = IorD ? alu_out : pc. FETCH always uses pc, regardless of IorD.
- FSM states: IDLE, REQ, DONE.
  - IDLE, command present, addr[1:0]=0:
    - At the next edge: mem_req=1, mem_addr=addr, mem_we=STORE, mem_wdata=wd (STORE only), timer=0, kind latched.
    - Go to REQ.
  - IDLE, command present, addr[1:0]!=0:
    - No bus cycle is issued.
    - align_err pulses for one cycle; instr and mdr are unchanged.
    - Go to DONE.
  - REQ, mem_ack=1:
    - mem_req and mem_we drop at this edge.
    - FETCH: instr <= mem_rdata. LOAD: mdr <= mem_rdata. STORE: neither register changes.
    - Go to DONE.
  - REQ, no ack, timer = TIMEOUT_CYC-1:
    - Abort: drop mem_req, bus_err pulses, registers are unchanged.
    - Go to DONE.
  - REQ, otherwise: timer increments; mem_addr, mem_we and mem_wdata stay stable.
  - DONE: unconditionally go to IDLE. This is a one-cycle guard so that a strobe still held by the control FSM does not re-issue.
- busy:
  - Combinational: busy = (state==REQ) | (state==IDLE & command present & aligned).
  - Drops in the cycle after the ack edge.
  - With a zero-wait memory (ack in the first REQ cycle), a fetch occupies 2 cycles and instr is valid in the DONE cycle.
- Boundary rules:
  - mem_ack outside REQ is ignored.
  - rst during REQ drops mem_req at that edge; a late ack is ignored.
  - mem_rdata is sampled only when mem_ack=1.
  - instr and mdr hold between accesses; instr changes only on a successful FETCH.
  - The timer saturates and never wraps.

Decomposition:
- Shared package mips_mc_pkg:
  - opcode/funct constants (LW 6'h23, SW 6'h2b, BEQ 6'h04, J 6'h02, JAL 6'h03, …).
  - FSM state encoding localparams.
  - instruction field bit positions.
  - TIMEOUT_CYC default.
- One natural sub-module: bus_timeout_timer (clear, enable, terminal-count output), reusable by future peripherals.

Test Plan:
- Fetch, zero-wait: pc=0x0000_0040, IR_Write=1, memory returns 0x2008_0005 with ack in the first REQ cycle -> mem_req high for 1 cycle with mem_addr=0x40; instr=0x20080005, Op=6'h08, rt=8, imm=5 in the DONE cycle; busy high for exactly 2 cycles.
- Load with wait states: IorD=1, alu_out=0x100, ack after 3 cycles with data 0xDEAD_BEEF -> mdr=0xDEADBEEF; instr unchanged; busy high for 4 cycles; mem_we=0 throughout.
- Store: Mem_Write=1, IorD=1, alu_out=0x104, wd=0x1234_5678 -> one bus cycle with mem_we=1, mem_wdata=0x12345678; mdr and instr unchanged; strobe held through DONE causes no second request.
- Misaligned/priority: alu_out=0x102 with Mem_Write=1 -> no mem_req, align_err for one cycle. Then IR_Write and Mem_Write together with pc=0x44 -> fetch issued with mem_we=0.
- Timeout: TIMEOUT_CYC=4, LOAD, no ack -> mem_req for 4 cycles, bus_err pulse, mdr unchanged, FSM back to IDLE after DONE.
- Reset mid-transfer: rst=1 during REQ -> mem_req=0 and all outputs 0 at that edge; ack in the following cycle leaves instr=0.
